ex_mem_stage: RTL
=================

# ex_mem_stage

Parametrised EX/MEM pipeline stage register with valid/ready flow control, synchronous flush and an optional skid entry. It replaces the free-running EX/MEM latch between the execute and memory stages. It carries the ALU result, store data, destination register address and a packed control vector. It stalls without losing data and turns flushed instructions into bubbles with all control bits zero.

## Interface
- DATA_W, 32: width of ALU result and store data
- ADDR_W, 5: width of destination register address
- CTRL_W, 4: width of packed control vector {RegWrite, MemtoReg, MemRead, MemWrite}
- SKID, 1: 1 = two-entry stage with registered ready_o; 0 = single entry with combinational ready_o
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- valid_i  in  1  EX presents a beat
- ready_o  out  1  stage can accept a beat
- ALUres_i  in  DATA_W  ALU result
- RS2data_i  in  DATA_W  store data
- RDaddr_i  in  ADDR_W  destination register
- ctrl_i  in  CTRL_W  control vector
- flush_i  in  1  kill all held beats
- valid_o  out  1  MEM-side beat valid
- ready_i  in  1  MEM stage accepts the beat
- ALUres_o, RS2data_o  out  DATA_W  head beat data
- RDaddr_o  out  ADDR_W  head beat destination
- ctrl_o  out  CTRL_W  head beat control; 0 whenever valid_o = 0
- occ_o  out  2  beats held (0..2)

## Operation
- Accept = valid_i & ready_o. Issue = valid_o & ready_i.
- Beats leave in arrival order. The skid entry always holds the younger beat.
- States for SKID=1:
  - EMPTY (occ 0): on accept, load main and go to FULL.
  - FULL (occ 1): accept & issue loads main and stays FULL. Accept & !issue loads skid and goes to SKID. Issue & !accept goes to EMPTY. Otherwise hold.
  - SKID (occ 2): ready_o = 0 and valid_i is ignored. Issue moves skid to main and goes to FULL. Otherwise hold.
- SKID=0 uses only EMPTY and FULL, with ready_o = !valid_o | ready_i. There is no skid register.
- ready_o for SKID=1 is a flop and equals (next state != SKID).
- flush_i forces EMPTY on the next edge and sets occ_o = 0.
  - Flush has priority over accept and issue in the same cycle. The incoming beat is dropped.
  - The MEM side still samples the current head that cycle; the flush does not retract it.
- ctrl register is written 0 whenever the next state is EMPTY. This covers reset, flush and drain.
- Data/address registers keep stale values when empty. Only ctrl_o is guaranteed 0.
- No arithmetic on the payload; widths pass through unchanged.

## Timing
- Reset values (asynchronous, while rst_i = 0):
  - valid_o = 0, ctrl_o = 0, ALUres_o = 0, RS2data_o = 0, RDaddr_o = 0, occ_o = 0.
  - ready_o = 1 (SKID=1 flop; for SKID=0 it follows from valid_o = 0).
  - Inputs are ignored while rst_i = 0.
- Latency: a beat accepted at edge N appears on the outputs after edge N. With ready_i held high, throughput is 1 beat per cycle.
- Deassertion of rst_i is synchronised externally. The first accept can occur on the first edge with rst_i = 1.
- Reset asserted mid-stall: held beats are lost immediately and the outputs take reset values asynchronously.
- SKID=1 has no combinational path from ready_i to ready_o. SKID=0 has one.
- Holding valid_i high while ready_o = 0 is legal. The beat stays on the inputs until accepted.

## Test plan
- Reset: drive valid_i = 1 and ALUres_i = 0x1234 with rst_i = 0 for 3 cycles.
  - Required: valid_o = 0, ctrl_o = 0, occ_o = 0, ready_o = 1 throughout.
  - First edge after release loads 0x1234; valid_o = 1.
- Streaming: send 8 beats with ALUres_i = 0..7, ready_i = 1, SKID=1.
  - Required: outputs 0..7 on consecutive cycles, one cycle after each accept.
  - occ_o stays 1 and ready_o stays 1.
- Backpressure: ready_i = 0 with beats A = 0xA, B = 0xB offered on back-to-back cycles.
  - Required: occ_o = 2, ready_o = 0, output holds A, C = 0xC held off.
  - Raise ready_i: output sequence A, B, C with no loss or duplication.
- Flush: occ_o = 2 with ctrl = 4'b1001 on both beats; assert flush_i together with valid_i.
  - Required: next cycle valid_o = 0, ctrl_o = 0, occ_o = 0, ready_o = 1; the incoming beat is dropped.
- SKID=0 build: ready_i = 0, valid_o = 1.
  - Required: ready_o = 0 combinationally.
  - Raising ready_i in the same cycle gives ready_o = 1; the new beat replaces the issued one at the edge.
- Async reset mid-stall: hold occ_o = 2 and pulse rst_i low between edges.
  - Required: outputs reach reset values before the next edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline stage register with valid/ready flow control, synchronous
// flush and an optional skid entry. Carries the ALU result, store data,
// destination register and packed control vector {RegWrite, MemtoReg,
// MemRead, MemWrite} from execute to memory. A stall never loses a beat, and
// a flushed or empty stage presents a bubble with every control bit zero.
//
// Parameters
//   DATA_W  width of ALU result and store data
//   ADDR_W  width of destination register address
//   CTRL_W  width of packed control vector
//   SKID    1 = two entries, registered ready_o; 0 = one entry, comb ready_o
//
// Ports
//   clk_i                  clock, rising edge
//   rst_i                  asynchronous active-low reset
//   valid_i / ready_o      EX-side handshake
//   ALUres_i, RS2data_i,
//   RDaddr_i, ctrl_i       incoming beat payload
//   flush_i                kill every held beat and the incoming one
//   valid_o / ready_i      MEM-side handshake
//   ALUres_o, RS2data_o,
//   RDaddr_o, ctrl_o       head beat payload (ctrl_o is 0 when empty)
//   occ_o                  beats held, 0..2
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] ALUres_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] ALUres_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic issue;
    logic load_main;
    logic move_skid;

    logic [DATA_W-1:0] main_alu;
    logic [DATA_W-1:0] main_rs2;
    logic [ADDR_W-1:0] main_rd;
    logic [CTRL_W-1:0] main_ctrl;

    logic [DATA_W-1:0] skid_alu;
    logic [DATA_W-1:0] skid_rs2;
    logic [ADDR_W-1:0] skid_rd;
    logic [CTRL_W-1:0] skid_ctrl;

    assign accept = valid_i & ready_o;
    assign issue  = valid_o & ready_i;

    // Main entry is written from the input when it is (or is about to become)
    // free, and from the skid entry when the head leaves while two are held.
    // Flush suppresses every load; the incoming beat is simply dropped.
    assign load_main = !flush_i && accept &&
                       ((state == ST_EMPTY) || ((state == ST_FULL) && issue));
    assign move_skid = !flush_i && issue && (state == ST_SKID);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_FULL;
                ST_FULL: begin
                    if (accept && !issue) begin
                        // Only reachable with a skid entry: the combinational
                        // ready of the single-entry build implies issue.
                        state_nxt = (SKID != 0) ? ST_SKID : ST_FULL;
                    end else if (issue && !accept) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: if (issue) state_nxt = ST_FULL;
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        valid_o = 1'b0;
        occ_o   = 2'd0;
        case (state)
            ST_FULL: begin
                valid_o = 1'b1;
                occ_o   = 2'd1;
            end
            ST_SKID: begin
                valid_o = 1'b1;
                occ_o   = 2'd2;
            end
            default: begin
                valid_o = 1'b0;
                occ_o   = 2'd0;
            end
        endcase
    end

    assign ALUres_o  = main_alu;
    assign RS2data_o = main_rs2;
    assign RDaddr_o  = main_rd;
    assign ctrl_o    = main_ctrl;

    // -----------------------------------------------------------------------
    // Main (head) entry
    // -----------------------------------------------------------------------
    // Control is cleared whenever the stage is about to be empty, so reset,
    // flush and drain all present a bubble. Payload keeps stale values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_alu  <= '0;
            main_rs2  <= '0;
            main_rd   <= '0;
            main_ctrl <= '0;
        end else begin
            if (load_main) begin
                main_alu <= ALUres_i;
                main_rs2 <= RS2data_i;
                main_rd  <= RDaddr_i;
            end else if (move_skid) begin
                main_alu <= skid_alu;
                main_rs2 <= skid_rs2;
                main_rd  <= skid_rd;
            end

            if (state_nxt == ST_EMPTY) begin
                main_ctrl <= '0;
            end else if (load_main) begin
                main_ctrl <= ctrl_i;
            end else if (move_skid) begin
                main_ctrl <= skid_ctrl;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Skid entry and ready generation
    // -----------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            logic load_skid;
            logic ready_q;

            // The skid entry always receives the younger beat: it is written
            // only when the head is occupied and not leaving.
            assign load_skid = !flush_i && accept && (state == ST_FULL) && !issue;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    skid_alu  <= '0;
                    skid_rs2  <= '0;
                    skid_rd   <= '0;
                    skid_ctrl <= '0;
                end else if (load_skid) begin
                    skid_alu  <= ALUres_i;
                    skid_rs2  <= RS2data_i;
                    skid_rd   <= RDaddr_i;
                    skid_ctrl <= ctrl_i;
                end
            end

            // Registered ready breaks the ready_i -> ready_o path.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nxt != ST_SKID);
                end
            end

            assign ready_o = ready_q;
        end else begin : g_no_skid
            assign skid_alu  = '0;
            assign skid_rs2  = '0;
            assign skid_rd   = '0;
            assign skid_ctrl = '0;
            assign ready_o   = !valid_o | ready_i;
        end
    endgenerate

endmodule
